debug_trace_fifo: RTL and testbench
===================================

Name: debug_trace_fifo

Overview:
Parametrised writeback trace buffer for the multi-issue core. It gathers up to LANES register-write retirements per cycle and compacts them in lane order into a circular queue. It drains them one per cycle to the difftest/trace port through a valid/ready handshake. It raises an early stall to the pipeline and tracks overflow with a sticky flag and a drop counter.

Parameters:
LANES, 2, number of writeback lanes; legal values 1..4; lane 0 is the oldest instruction.
DEPTH, 32, number of queue entries; power of two; minimum 4; must be at least 2*LANES.
AW, $clog2(DEPTH), pointer width (derived, not overridable).
DROP_W, 16, width of the drop counter.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
inst_addr_i  input  LANES*32  retiring PC per lane; lane k occupies bits [32k+31:32k].
reg_write_i  input  LANES  register-write valid per lane.
reg_waddr_i  input  LANES*5  destination register per lane.
reg_wdata_i  input  LANES*32  writeback data per lane.
trace_ready_i  input  1  consumer accepts the head entry this cycle.
clr_ovf_i  input  1  clears overflow_o and drop_cnt_o.
trace_valid_o  output  1  the head entry is valid.
inst_addr_o  output  32  head entry PC.
reg_write_o  output  4  head write enable, replicated on all 4 bits.
reg_waddr_o  output  5  head destination register.
reg_wdata_o  output  32  head writeback data.
count_o  output  AW+1  number of occupied entries.
stall_o  output  1  free entries < LANES; the pipeline must hold writeback.
overflow_o  output  1  sticky: at least one retirement group was dropped.
drop_cnt_o  output  DROP_W  number of dropped individual writes; saturates.

Behaviour:
- Reset (rst==0 at a clock edge):
  - head, tail, count, overflow_o and drop_cnt_o all go to 0.
  - Queue RAM contents are don't-care.
  - After reset, all outputs read 0 and stall_o reads 0.
- Push count:
  - n = popcount(reg_write_i), range 0..LANES.
  - free = DEPTH - count, using the registered count only; a same-cycle pop gives no credit.
- Accept (n <= free):
  - Writing lanes are written in ascending lane order to entries tail, tail+1, ..., tail+n-1.
  - Idle lanes are skipped, so there are no holes in the queue.
  - tail advances by n, modulo DEPTH.
- Drop (n > free):
  - The whole group is dropped; no partial enqueue occurs.
  - tail does not move.
  - overflow_o is set to 1.
  - drop_cnt_o increases by n and saturates at 2^DROP_W - 1.
- Pop:
  - A pop occurs when trace_valid_o && trace_ready_i.
  - head advances by 1, modulo DEPTH.
- Count:
  - count_next = count + accepted_n - pop.
  - Push and pop may happen in the same cycle; count never exceeds DEPTH and never goes below 0.
- Output path:
  - trace_valid_o = (count != 0).
  - Data outputs read the entry at head combinationally.
  - All data outputs are forced to 0 when trace_valid_o == 0.
- Latency: an entry accepted at edge N is visible on the outputs after edge N when the queue was empty (one-cycle latency). Fall-through from input to output in the same cycle is not allowed.
- Ordering: output order is strictly cycle order, then lane order within a cycle.
- Stall:
  - stall_o = (DEPTH - count) < LANES; purely combinational from the registered count.
  - With stall honoured by the pipeline, a drop can never occur.
- Clear:
  - clr_ovf_i has priority over a same-cycle drop: overflow_o and drop_cnt_o are both 0 next cycle.
  - The queue itself is unaffected.
- Wrap-around: pointers wrap naturally at DEPTH. A multi-lane write that straddles the last entry continues at index 0.
- Reset mid-operation: the queue is flushed. Pending entries are lost and no output handshake completes in the reset cycle.

Test Plan:
1. LANES=2, DEPTH=8. After reset, trace_valid_o=0, all data outputs 0, count_o=0, stall_o=0 -> correct reset state.
2. Cycle 1: both lanes write (PC 0x100 r1=0x11, PC 0x104 r2=0x22). trace_ready_i=1 from cycle 2. -> Output 0x100/r1/0x11 then 0x104/r2/0x22, reg_write_o=4'hF, then trace_valid_o=0.
3. Lane 1 only writes (PC 0x208 r5=0xAB) while lane 0 is idle -> enqueued as one entry, count_o=1, output 0x208/r5.
4. trace_ready_i=0, fill 7 entries -> stall_o=1. A further 2-lane push -> dropped, overflow_o=1, drop_cnt_o=2, count_o=7. Then assert clr_ovf_i -> overflow_o=0, drop_cnt_o=0.
5. Wrap-around: bring tail to 7, then push 2 entries with a continuous pop -> entries are stored at indices 7 and 0 and emerge in order; count stays consistent through simultaneous push and pop.
6. Hold 3 entries with trace_ready_i=0, then rst=0 for one cycle -> count_o=0, trace_valid_o=0. Pushes after reset are output correctly starting from index 0.

Source files
------------

// File: rtl/debug_trace_fifo.sv
// Writeback trace buffer: compacts up to LANES register-write retirements per cycle
// into a circular queue and drains them one per cycle over a valid/ready port.
module debug_trace_fifo #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 32,
  parameter int DROP_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES*32-1:0]   inst_addr_i,
  input  logic [LANES-1:0]      reg_write_i,
  input  logic [LANES*5-1:0]    reg_waddr_i,
  input  logic [LANES*32-1:0]   reg_wdata_i,
  input  logic                  trace_ready_i,
  input  logic                  clr_ovf_i,
  output logic                  trace_valid_o,
  output logic [31:0]           inst_addr_o,
  output logic [3:0]            reg_write_o,
  output logic [4:0]            reg_waddr_o,
  output logic [31:0]           reg_wdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                  stall_o,
  output logic                  overflow_o,
  output logic [DROP_W-1:0]     drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [31:0] pc_mem    [DEPTH];
  logic [4:0]  waddr_mem [DEPTH];
  logic [31:0] wdata_mem [DEPTH];

  logic [AW-1:0] offs   [LANES];
  logic [AW-1:0] wr_idx [LANES];
  logic [CW-1:0] n_push;
  logic [CW-1:0] free_ent;
  logic          accept;
  logic          pop;
  logic [DROP_W:0] drop_sum;

  // Each writing lane lands at tail + (number of writing lanes below it), so idle lanes leave no holes.
  always_comb begin
    offs[0] = '0;
    for (int k = 1; k < LANES; k++) begin
      offs[k] = offs[k-1] + AW'(reg_write_i[k-1]);
    end
    for (int k = 0; k < LANES; k++) begin
      wr_idx[k] = tail_q + offs[k];
    end
    n_push = CW'(offs[LANES-1]) + CW'(reg_write_i[LANES-1]);
  end

  assign free_ent = CW'(DEPTH) - count_q;
  assign accept   = (n_push <= free_ent);
  assign pop      = trace_valid_o & trace_ready_i;
  assign drop_sum = {1'b0, drop_q} + (DROP_W+1)'(n_push);

  always_comb begin
    head_d  = head_q + AW'(pop);
    tail_d  = accept ? tail_q + AW'(n_push) : tail_q;
    count_d = count_q + (accept ? n_push : '0) - CW'(pop);
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (clr_ovf_i) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (!accept) begin
      ovf_d  = 1'b1;
      drop_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (reg_write_i[k]) begin
          pc_mem[wr_idx[k]]    <= inst_addr_i[32*k +: 32];
          waddr_mem[wr_idx[k]] <= reg_waddr_i[5*k +: 5];
          wdata_mem[wr_idx[k]] <= reg_wdata_i[32*k +: 32];
        end
      end
    end
  end

  assign trace_valid_o = (count_q != '0);
  assign inst_addr_o   = trace_valid_o ? pc_mem[head_q]    : '0;
  assign reg_waddr_o   = trace_valid_o ? waddr_mem[head_q] : '0;
  assign reg_wdata_o   = trace_valid_o ? wdata_mem[head_q] : '0;
  assign reg_write_o   = {4{trace_valid_o}};
  assign count_o       = count_q;
  assign stall_o       = (free_ent < CW'(LANES));
  assign overflow_o    = ovf_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_debug_trace_fifo.sv
// Bench for debug_trace_fifo: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the trace buffer.
module tb_debug_trace_fifo;

  localparam int LANES  = 2;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 16;
  localparam int AW     = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } entry_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [LANES*32-1:0]   inst_addr_i;
  logic [LANES-1:0]      reg_write_i;
  logic [LANES*5-1:0]    reg_waddr_i;
  logic [LANES*32-1:0]   reg_wdata_i;
  logic                  trace_ready_i;
  logic                  clr_ovf_i;
  logic                  trace_valid_o;
  logic [31:0]           inst_addr_o;
  logic [3:0]            reg_write_o;
  logic [4:0]            reg_waddr_o;
  logic [31:0]           reg_wdata_o;
  logic [AW:0]           count_o;
  logic                  stall_o;
  logic                  overflow_o;
  logic [DROP_W-1:0]     drop_cnt_o;

  debug_trace_fifo #(.LANES(LANES), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst),
    .inst_addr_i(inst_addr_i), .reg_write_i(reg_write_i),
    .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .trace_ready_i(trace_ready_i), .clr_ovf_i(clr_ovf_i),
    .trace_valid_o(trace_valid_o), .inst_addr_o(inst_addr_o),
    .reg_write_o(reg_write_o), .reg_waddr_o(reg_waddr_o),
    .reg_wdata_o(reg_wdata_o), .count_o(count_o), .stall_o(stall_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  entry_t mq[$];
  logic   m_ovf;
  int     m_drop;
  int     n_chk  = 0;
  int     n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_outputs();
    logic v;
    entry_t h;
    v = (mq.size() != 0);
    h = v ? mq[0] : '0;
    chk("valid", 64'(trace_valid_o), 64'(v));
    chk("pc", 64'(inst_addr_o), 64'(h.pc));
    chk("we", 64'(reg_write_o), v ? 64'hF : 64'h0);
    chk("waddr", 64'(reg_waddr_o), 64'(h.waddr));
    chk("wdata", 64'(reg_wdata_o), 64'(h.wdata));
    chk("count", 64'(count_o), 64'(mq.size()));
    chk("stall", 64'(stall_o), 64'((DEPTH - mq.size()) < LANES));
    chk("ovf", 64'(overflow_o), 64'(m_ovf));
    chk("drop", 64'(drop_cnt_o), 64'(m_drop));
  endtask

  // Drive one cycle from the negedge, update the model, then check at the next negedge.
  task automatic step(input logic [LANES-1:0] we, input logic [LANES*32-1:0] pcs,
                      input logic [LANES*5-1:0] ras, input logic [LANES*32-1:0] wds,
                      input logic rdy, input logic clr);
    int n, free;
    entry_t e;
    inst_addr_i = pcs; reg_write_i = we; reg_waddr_i = ras; reg_wdata_i = wds;
    trace_ready_i = rdy; clr_ovf_i = clr;
    n = 0;
    for (int k = 0; k < LANES; k++) n += int'(we[k]);
    free = DEPTH - mq.size();
    if (rdy && mq.size() != 0) void'(mq.pop_front());
    if (n <= free) begin
      for (int k = 0; k < LANES; k++) begin
        if (we[k]) begin
          e.pc = pcs[32*k +: 32]; e.waddr = ras[5*k +: 5]; e.wdata = wds[32*k +: 32];
          mq.push_back(e);
        end
      end
    end else begin
      m_ovf  = 1'b1;
      m_drop = (m_drop + n > (1 << DROP_W) - 1) ? (1 << DROP_W) - 1 : m_drop + n;
    end
    if (clr) begin
      m_ovf = 1'b0; m_drop = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic step_rand(input int we_pct, input int rdy_pct, input int clr_pct);
    logic [LANES-1:0] we;
    logic [LANES*32-1:0] pcs, wds;
    logic [LANES*5-1:0] ras;
    for (int k = 0; k < LANES; k++) begin
      we[k] = ($urandom_range(99) < we_pct);
      pcs[32*k +: 32] = $urandom;
      wds[32*k +: 32] = $urandom;
      ras[5*k +: 5]   = 5'($urandom);
    end
    step(we, pcs, ras, wds, $urandom_range(99) < rdy_pct, $urandom_range(99) < clr_pct);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    reg_write_i = LANES'($urandom); trace_ready_i = 1'b1; clr_ovf_i = 1'b0;
    inst_addr_i = {$urandom, $urandom}; reg_wdata_i = {$urandom, $urandom};
    reg_waddr_i = 10'($urandom);
    @(posedge clk);
    @(negedge clk);
    mq.delete(); m_ovf = 1'b0; m_drop = 0;
    rst = 1'b1;
    check_outputs();
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [4:0] ra, input logic [31:0] wd,
                          input logic rdy);
    step(2'b01, {32'h0, pc}, {5'h0, ra}, {32'h0, wd}, rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b0; inst_addr_i = '0; reg_write_i = '0; reg_waddr_i = '0; reg_wdata_i = '0;
    trace_ready_i = 1'b0; clr_ovf_i = 1'b0; m_ovf = 1'b0; m_drop = 0;
    @(negedge clk);
    do_reset();

    // two-lane push, drained in lane order
    step(2'b11, {32'h104, 32'h100}, {5'd2, 5'd1}, {32'h22, 32'h11}, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b00, '0, '0, '0, 1'b1, 1'b0);

    // lane 1 only
    step(2'b10, {32'h208, 32'h0}, {5'd5, 5'd0}, {32'hAB, 32'h0}, 1'b0, 1'b0);
    step(2'b00, '0, '0, '0, 1'b1, 1'b0);

    // fill to 7, dropped group, then clear
    for (int i = 0; i < 7; i++) push_one(32'h300 + 32'(4*i), 5'(i + 1), $urandom, 1'b0);
    step(2'b11, {32'h400, 32'h3FC}, {5'd9, 5'd8}, {32'h99, 32'h88}, 1'b0, 1'b0);
    step(2'b00, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(2'b00, '0, '0, '0, 1'b1, 1'b0);

    // wrap: tail to 7 with continuous pop, then a straddling two-lane push
    do_reset();
    for (int i = 0; i < 7; i++) push_one(32'h500 + 32'(4*i), 5'(i), $urandom, 1'b1);
    step(2'b11, {32'h604, 32'h600}, {5'd11, 5'd10}, {32'hB1, 32'hA1}, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b00, '0, '0, '0, 1'b1, 1'b0);

    // reset with entries pending
    for (int i = 0; i < 3; i++) push_one(32'h700 + 32'(4*i), 5'(i), $urandom, 1'b0);
    do_reset();
    step(2'b11, {32'h804, 32'h800}, {5'd4, 5'd3}, {32'hD2, 32'hD1}, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b00, '0, '0, '0, 1'b1, 1'b0);

    // random traffic in several regimes
    for (int i = 0; i < 400; i++) step_rand(60, 50, 2);
    for (int i = 0; i < 200; i++) step_rand(90, 20, 5);
    for (int i = 0; i < 200; i++) step_rand(30, 90, 1);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 50; i++) step_rand(70, 40, 3);
      do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
